// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response and program-load bus between a requester and imem_fetch_responder.
// The master drives request and load signals; the slave (responder) drives the response.
interface imem_fetch_responder_if #(
   parameter int n_bit = 8
);
   logic             req;
   logic [n_bit-1:0] pc;
   logic             busy;
   logic             valid;
   logic [31:0]      instr;
   logic             misalign;
   logic             ld_en;
   logic [n_bit-3:0] ld_addr;
   logic [31:0]      ld_data;

   modport master (
      output req, pc, ld_en, ld_addr, ld_data,
      input  busy, valid, instr, misalign
   );

   modport slave (
      input  req, pc, ld_en, ld_addr, ld_data,
      output busy, valid, instr, misalign
   );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: accepts a PC fetch, waits WAIT_STATES cycles, returns one word.
// Optional feature macro: IMEM_MISALIGN_TRAP_EN (misaligned fetches answer at once with a NOP).
module imem_fetch_responder #(
   parameter int n_bit       = 8,
   parameter int WAIT_STATES = 2
) (
   input logic                  clk,
   input logic                  reset_n,
   imem_fetch_responder_if.slave bus
);
   localparam int         DEPTH   = 2 ** (n_bit - 2);
   localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [3:0]       r_cnt;
   logic [n_bit-3:0] r_addr;
   logic [31:0]      r_instr;
   logic             r_misalign;
   logic [31:0]      r_mem [DEPTH];

   logic             w_accept;
   logic             w_trap;
   logic             w_doRead;
   logic             w_doTrap;
   logic             w_loadCnt;
   logic [n_bit-3:0] w_readIdx;

`ifdef IMEM_MISALIGN_TRAP_EN
   assign w_trap = (bus.pc[1:0] != 2'b00);
`else
   logic w_unusedPcBits;
   assign w_trap         = 1'b0;
   assign w_unusedPcBits = ^bus.pc[1:0];
`endif

   assign w_accept = (r_state == IDLE) && bus.req;

   // With zero wait states the read happens on the accept edge, before r_addr holds the index.
   assign w_readIdx = (r_state == IDLE) ? bus.pc[n_bit-1:2] : r_addr;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_doRead    = 1'b0;
      w_doTrap    = 1'b0;
      w_loadCnt   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.req) begin
               if (w_trap) begin
                  w_nextState = RESP;
                  w_doTrap    = 1'b1;
               end else if (WAIT_STATES == 0) begin
                  w_nextState = RESP;
                  w_doRead    = 1'b1;
               end else begin
                  w_nextState = WAIT;
                  w_loadCnt   = 1'b1;
               end
            end
         end
         WAIT: begin
            if (r_cnt <= 4'd1) begin
               w_nextState = RESP;
               w_doRead    = 1'b1;
            end
         end
         RESP: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt      <= 4'd0;
         r_addr     <= '0;
         r_instr    <= 32'h0;
         r_misalign <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr <= bus.pc[n_bit-1:2];
         end
         if (w_loadCnt) begin
            r_cnt <= LP_WAIT;
         end else if ((r_state == WAIT) && (r_cnt > 4'd1)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_doRead) begin
            r_instr    <= r_mem[w_readIdx];
            r_misalign <= 1'b0;
         end else if (w_doTrap) begin
            r_instr    <= 32'h0;
            r_misalign <= 1'b1;
         end
      end
   end

   // Program storage survives reset; a same-edge write never disturbs the read above.
   always_ff @(posedge clk) begin
      if (bus.ld_en) begin
         r_mem[bus.ld_addr] <= bus.ld_data;
      end
   end

   assign bus.busy     = (r_state != IDLE);
   assign bus.valid    = (r_state == RESP);
   assign bus.instr    = r_instr;
   assign bus.misalign = r_misalign;
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Randomized self-checking bench for imem_fetch_responder: two instances (2 and 0 wait states)
// checked against a transaction-level memory/latency model.
module tb_imem_fetch_responder;
   localparam int NB = 8;

`ifdef IMEM_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   imem_fetch_responder_if #(.n_bit(NB)) busA ();
   imem_fetch_responder_if #(.n_bit(NB)) busB ();

   imem_fetch_responder #(.n_bit(NB), .WAIT_STATES(2)) dutA (
      .clk(clk), .reset_n(reset_n), .bus(busA)
   );
   imem_fetch_responder #(.n_bit(NB), .WAIT_STATES(0)) dutB (
      .clk(clk), .reset_n(reset_n), .bus(busB)
   );

   logic        tReq    [2];
   logic [7:0]  tPc     [2];
   logic        tLdEn   [2];
   logic [5:0]  tLdAddr [2];
   logic [31:0] tLdData [2];
   logic        oValid    [2];
   logic        oBusy     [2];
   logic        oMisalign [2];
   logic [31:0] oInstr    [2];

   assign busA.req = tReq[0];  assign busA.pc = tPc[0];  assign busA.ld_en = tLdEn[0];
   assign busA.ld_addr = tLdAddr[0];  assign busA.ld_data = tLdData[0];
   assign busB.req = tReq[1];  assign busB.pc = tPc[1];  assign busB.ld_en = tLdEn[1];
   assign busB.ld_addr = tLdAddr[1];  assign busB.ld_data = tLdData[1];
   assign oValid[0] = busA.valid;  assign oBusy[0] = busA.busy;
   assign oMisalign[0] = busA.misalign;  assign oInstr[0] = busA.instr;
   assign oValid[1] = busB.valid;  assign oBusy[1] = busB.busy;
   assign oMisalign[1] = busB.misalign;  assign oInstr[1] = busB.instr;

   logic [31:0] modelMem [2][64];
   int          waitOf   [2];
   int          checkCount = 0;
   int          errorCount = 0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // One clock edge with the given inputs; outputs are sampled 1 time unit after the edge.
   task automatic applyStimulus(input int sel, input logic req, input logic [7:0] pc,
                                input logic ldEn, input logic [5:0] ldAddr, input logic [31:0] ldData);
      tReq[sel]    = req;
      tPc[sel]     = pc;
      tLdEn[sel]   = ldEn;
      tLdAddr[sel] = ldAddr;
      tLdData[sel] = ldData;
      @(posedge clk);
      #1;
      if (ldEn) modelMem[sel][ldAddr] = ldData;
      tLdEn[sel] = 1'b0;
   endtask

   task automatic writeWord(input int sel, input logic [5:0] addr, input logic [31:0] data);
      applyStimulus(sel, 1'b0, 8'h00, 1'b1, addr, data);
   endtask

   task automatic idleCycles(input int sel, input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(sel, 1'b0, 8'($urandom), 1'($urandom), 6'($urandom), $urandom);
         checkOutput("idle_valid", 32'(oValid[sel]), 32'd0);
         checkOutput("idle_busy", 32'(oBusy[sel]), 32'd0);
      end
   endtask

   // Issue one fetch from IDLE. plantK >= 0 forces a load on edge E0+plantK; otherwise loads
   // are random when randLoads is set. The response is expected after edge E0+latency.
   task automatic runFetch(input int sel, input logic [7:0] pc, input int plantK,
                           input logic [5:0] plantAddr, input logic [31:0] plantData,
                           input bit randLoads, input bit holdReq);
      bit          trap;
      int          lat;
      logic [31:0] expInstr;
      logic        ldEn;
      logic [5:0]  la;
      logic [31:0] ld;
      logic [7:0]  drivePc;
      trap     = TRAP_EN && (pc[1:0] != 2'b00);
      lat      = trap ? 0 : waitOf[sel];
      expInstr = 32'h0;
      for (int k = 0; k <= lat; k++) begin
         if (k == plantK) begin
            ldEn = 1'b1;  la = plantAddr;  ld = plantData;
         end else if (randLoads) begin
            ldEn = 1'($urandom);
            la   = ($urandom_range(0, 1) == 0) ? pc[7:2] : 6'($urandom);
            ld   = $urandom;
         end else begin
            ldEn = 1'b0;  la = 6'd0;  ld = 32'h0;
         end
         if (k == lat && !trap) expInstr = modelMem[sel][pc[7:2]];
         drivePc = (k == 0) ? pc : 8'($urandom);
         applyStimulus(sel, 1'b1, drivePc, ldEn, la, ld);
         checkOutput("busy_after_accept", 32'(oBusy[sel]), 32'd1);
         if (k < lat) begin
            checkOutput("valid_early", 32'(oValid[sel]), 32'd0);
         end else begin
            checkOutput("valid_resp", 32'(oValid[sel]), 32'd1);
            checkOutput("instr_resp", oInstr[sel], expInstr);
            checkOutput("misalign_resp", 32'(oMisalign[sel]), 32'(trap));
         end
      end
      applyStimulus(sel, holdReq, 8'($urandom), 1'b0, 6'd0, 32'h0);
      checkOutput("valid_pulse_end", 32'(oValid[sel]), 32'd0);
      checkOutput("busy_release", 32'(oBusy[sel]), 32'd0);
      checkOutput("instr_hold", oInstr[sel], expInstr);
   endtask

   initial begin
      int gap;
      int nextGap;
      waitOf[0] = 2;
      waitOf[1] = 0;
      for (int s = 0; s < 2; s++) begin
         tReq[s] = 1'b0;  tPc[s] = 8'h0;  tLdEn[s] = 1'b0;  tLdAddr[s] = 6'h0;  tLdData[s] = 32'h0;
      end
      reset_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         checkOutput("rst_valid", 32'(oValid[s]), 32'd0);
         checkOutput("rst_busy", 32'(oBusy[s]), 32'd0);
         checkOutput("rst_instr", oInstr[s], 32'h0);
         checkOutput("rst_misalign", 32'(oMisalign[s]), 32'd0);
      end
      reset_n = 1'b1;

      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 64; a++) writeWord(s, 6'(a), $urandom);
      end

      writeWord(0, 6'd7, 32'h2008000A);
      runFetch(0, 8'h1C, -1, 6'd0, 32'h0, 1'b0, 1'b0);

      writeWord(1, 6'd10, 32'hAC090004);
      runFetch(1, 8'h28, -1, 6'd0, 32'h0, 1'b0, 1'b1);
      runFetch(1, 8'h28, -1, 6'd0, 32'h0, 1'b0, 1'b1);
      runFetch(1, 8'h28, -1, 6'd0, 32'h0, 1'b0, 1'b0);

      runFetch(0, 8'h1C, 1, 6'd7, 32'h12345678, 1'b0, 1'b0);
      runFetch(0, 8'h1C, 2, 6'd7, 32'hDEADBEEF, 1'b0, 1'b0);
      runFetch(0, 8'h1C, -1, 6'd0, 32'h0, 1'b0, 1'b0);

      applyStimulus(0, 1'b1, 8'h2C, 1'b0, 6'd0, 32'h0);
      checkOutput("midrst_busy_e0", 32'(oBusy[0]), 32'd1);
      reset_n = 1'b0;
      applyStimulus(0, 1'b0, 8'h00, 1'b0, 6'd0, 32'h0);
      checkOutput("midrst_valid", 32'(oValid[0]), 32'd0);
      checkOutput("midrst_busy", 32'(oBusy[0]), 32'd0);
      checkOutput("midrst_instr", oInstr[0], 32'h0);
      reset_n = 1'b1;
      idleCycles(0, 4);
      runFetch(0, 8'h2C, -1, 6'd0, 32'h0, 1'b0, 1'b0);

      writeWord(0, 6'd10, 32'hCAFE0010);
      runFetch(0, 8'h2A, -1, 6'd0, 32'h0, 1'b0, 1'b0);
      runFetch(1, 8'h2A, -1, 6'd0, 32'h0, 1'b0, 1'b0);

      for (int s = 0; s < 2; s++) begin
         gap = $urandom_range(0, 3);
         idleCycles(s, gap + 1);
         for (int t = 0; t < 40; t++) begin
            nextGap = $urandom_range(0, 3);
            runFetch(s, 8'($urandom), -1, 6'd0, 32'h0, 1'b1, nextGap == 0);
            idleCycles(s, nextGap);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end
endmodule
